// File: rtl/fifo_pkg.sv
// ============================================================
// Module   : fifo_pkg
// Brief    : Shared FIFO mode selectors and default geometry.
// Revision : 1.0
// ============================================================
`default_nettype none

package fifo_pkg;
   localparam int FIFO_MODE_STD      = 0;
   localparam int FIFO_MODE_FWFT     = 1;
   localparam int FIFO_DEFAULT_WIDTH = 8;
   localparam int FIFO_DEFAULT_DEPTH = 16;
endpackage

`default_nettype wire

// File: rtl/fifo_mem.sv
// ============================================================
// Module   : fifo_mem
// Brief    : Simple dual-port storage, synchronous write, asynchronous read.
// Revision : 1.0
// ============================================================
`default_nettype none

module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DEFAULT_WIDTH,
   parameter int DEPTH      = FIFO_DEFAULT_DEPTH,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

`default_nettype wire

// File: rtl/sync_fifo_flex.sv
// ============================================================
// Module   : sync_fifo_flex
// Brief    : Single-clock FIFO with level flags, sticky errors and
//            selectable registered or first-word-fall-through read.
// Revision : 1.0
// ============================================================
`default_nettype none

module sync_fifo_flex
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DEFAULT_WIDTH,
   parameter int FIFO_DEPTH = FIFO_DEFAULT_DEPTH,
   parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
   parameter int AF_THRESH  = FIFO_DEPTH - 2,
   parameter int AE_THRESH  = 2,
   parameter int FWFT       = FIFO_MODE_STD
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  write_en,
   input  logic                  read_en,
   input  logic                  flush,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH:0] c_af    = (ADDR_WIDTH + 1)'(AF_THRESH);
   localparam logic [ADDR_WIDTH:0] c_ae    = (ADDR_WIDTH + 1)'(AE_THRESH);

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   level_q, level_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  w_rd_acc;
   logic                  w_wr_acc;
   logic [DATA_WIDTH-1:0] w_rd_data;

   assign full         = (level_q == c_depth);
   assign empty        = (level_q == '0);
   assign almost_full  = (level_q >= c_af);
   assign almost_empty = (level_q <= c_ae);
   assign level        = level_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   // A pop frees a slot on the same edge, so a full FIFO still takes a write.
   assign w_rd_acc = read_en && !empty && !flush;
   assign w_wr_acc = write_en && (!full || w_rd_acc) && !flush;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         level_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (w_wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (w_rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         if (w_wr_acc && !w_rd_acc) begin
            level_d = level_q + 1'b1;
         end else if (w_rd_acc && !w_wr_acc) begin
            level_d = level_q - 1'b1;
         end
         overflow_d  = overflow_q  | (write_en && full && !w_rd_acc);
         underflow_d = underflow_q | (read_en && empty);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (w_wr_acc),
      .wr_addr (wr_ptr_q),
      .wr_data (data_in),
      .rd_addr (rd_ptr_q),
      .rd_data (w_rd_data)
   );

   generate
      if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
         // Storage is never reset, so mask the head while nothing is stored.
         assign data_out   = empty ? '0 : w_rd_data;
         assign data_valid = !empty;
      end else begin : g_std
         logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
         logic                  data_valid_q, data_valid_d;

         always_comb begin
            data_out_d   = data_out_q;
            data_valid_d = w_rd_acc;
            if (w_rd_acc) begin
               data_out_d = w_rd_data;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               data_out_q   <= '0;
               data_valid_q <= 1'b0;
            end else begin
               data_out_q   <= data_out_d;
               data_valid_q <= data_valid_d;
            end
         end

         assign data_out   = data_out_q;
         assign data_valid = data_valid_q;
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_flex.sv
// ============================================================
// Module   : tb_sync_fifo_flex
// Brief    : Self-checking bench driving a registered-read and a FWFT
//            instance with identical stimulus against a queue model.
// Revision : 1.0
// ============================================================
`default_nettype none

module tb_sync_fifo_flex;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data_in;
   logic       write_en, read_en, flush;

   logic [7:0] s_dout, f_dout;
   logic       s_dv, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
   logic       f_dv, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
   logic [2:0] s_level, f_level;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] m_q[$];
   logic [7:0] m_dout;
   bit         m_dv, m_ovf, m_udf;

   always #5 clk = ~clk;

   sync_fifo_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .ADDR_WIDTH(2), .AF_THRESH(3),
                    .AE_THRESH(1), .FWFT(0)) u_std (
      .clk(clk), .rst(rst), .data_in(data_in), .write_en(write_en), .read_en(read_en),
      .flush(flush), .data_out(s_dout), .data_valid(s_dv), .full(s_full), .empty(s_empty),
      .almost_full(s_af), .almost_empty(s_ae), .level(s_level), .overflow(s_ovf),
      .underflow(s_udf));

   sync_fifo_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .ADDR_WIDTH(2), .AF_THRESH(3),
                    .AE_THRESH(1), .FWFT(1)) u_fwft (
      .clk(clk), .rst(rst), .data_in(data_in), .write_en(write_en), .read_en(read_en),
      .flush(flush), .data_out(f_dout), .data_valid(f_dv), .full(f_full), .empty(f_empty),
      .almost_full(f_af), .almost_empty(f_ae), .level(f_level), .overflow(f_ovf),
      .underflow(f_udf));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_dout = 8'h00;
      m_dv   = 1'b0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
   endtask

   task automatic model_step(input bit we, input bit re, input bit fl, input logic [7:0] din);
      bit rd_ok, wr_ok;
      if (fl) begin
         m_q.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
         m_dv  = 1'b0;
      end else begin
         rd_ok = re && (m_q.size() > 0);
         wr_ok = we && ((m_q.size() < 4) || rd_ok);
         if (we && m_q.size() == 4 && !rd_ok) m_ovf = 1'b1;
         if (re && m_q.size() == 0) m_udf = 1'b1;
         m_dv = rd_ok;
         if (rd_ok) m_dout = m_q.pop_front();
         if (wr_ok) m_q.push_back(din);
      end
   endtask

   task automatic check_model();
      int lv;
      lv = m_q.size();
      chk("std.level", 32'(s_level), 32'(lv));
      chk("std.full", 32'(s_full), 32'(lv == 4));
      chk("std.empty", 32'(s_empty), 32'(lv == 0));
      chk("std.almost_full", 32'(s_af), 32'(lv >= 3));
      chk("std.almost_empty", 32'(s_ae), 32'(lv <= 1));
      chk("std.overflow", 32'(s_ovf), 32'(m_ovf));
      chk("std.underflow", 32'(s_udf), 32'(m_udf));
      chk("std.data_out", 32'(s_dout), 32'(m_dout));
      chk("std.data_valid", 32'(s_dv), 32'(m_dv));
      chk("fwft.level", 32'(f_level), 32'(lv));
      chk("fwft.full", 32'(f_full), 32'(lv == 4));
      chk("fwft.empty", 32'(f_empty), 32'(lv == 0));
      chk("fwft.overflow", 32'(f_ovf), 32'(m_ovf));
      chk("fwft.underflow", 32'(f_udf), 32'(m_udf));
      chk("fwft.data_out", 32'(f_dout), (lv > 0) ? 32'(m_q[0]) : 32'h0);
      chk("fwft.data_valid", 32'(f_dv), 32'(lv > 0));
   endtask

   task automatic step(input bit we, input bit re, input bit fl, input logic [7:0] din);
      write_en = we;
      read_en  = re;
      flush    = fl;
      data_in  = din;
      @(posedge clk);
      model_step(we, re, fl, din);
      #1;
      check_model();
   endtask

   typedef struct {
      bit         we, re, fl;
      logic [7:0] din;
      int         lvl;
      bit         full, af, ovf, udf, dv;
      logic [7:0] dout;
   } vec_t;

   vec_t tbl[12];

   initial begin
      // we re fl din   lvl full af ovf udf dv dout
      tbl[0]  = '{1, 0, 0, 8'h11, 1, 0, 0, 0, 0, 0, 8'h00};
      tbl[1]  = '{1, 0, 0, 8'h22, 2, 0, 0, 0, 0, 0, 8'h00};
      tbl[2]  = '{1, 0, 0, 8'h33, 3, 0, 1, 0, 0, 0, 8'h00};
      tbl[3]  = '{1, 0, 0, 8'h44, 4, 1, 1, 0, 0, 0, 8'h00};
      tbl[4]  = '{1, 0, 0, 8'h55, 4, 1, 1, 1, 0, 0, 8'h00};
      tbl[5]  = '{0, 1, 0, 8'h00, 3, 0, 1, 1, 0, 1, 8'h11};
      tbl[6]  = '{0, 1, 0, 8'h00, 2, 0, 0, 1, 0, 1, 8'h22};
      tbl[7]  = '{0, 0, 0, 8'h00, 2, 0, 0, 1, 0, 0, 8'h22};
      tbl[8]  = '{0, 1, 0, 8'h00, 1, 0, 0, 1, 0, 1, 8'h33};
      tbl[9]  = '{0, 1, 0, 8'h00, 0, 0, 0, 1, 0, 1, 8'h44};
      tbl[10] = '{0, 1, 0, 8'h00, 0, 0, 0, 1, 1, 0, 8'h44};
      tbl[11] = '{0, 0, 0, 8'h00, 0, 0, 0, 1, 1, 0, 8'h44};

      rst = 1'b1; write_en = 1'b0; read_en = 1'b0; flush = 1'b0; data_in = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset.std.empty", 32'(s_empty), 32'h1);
      chk("reset.std.almost_empty", 32'(s_ae), 32'h1);
      chk("reset.std.data_out", 32'(s_dout), 32'h0);
      chk("reset.fwft.data_valid", 32'(f_dv), 32'h0);
      check_model();
      rst = 1'b0;

      // Fill past full, then drain past empty
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].we, tbl[i].re, tbl[i].fl, tbl[i].din);
         chk($sformatf("tbl%0d.level", i), 32'(s_level), 32'(tbl[i].lvl));
         chk($sformatf("tbl%0d.full", i), 32'(s_full), 32'(tbl[i].full));
         chk($sformatf("tbl%0d.almost_full", i), 32'(s_af), 32'(tbl[i].af));
         chk($sformatf("tbl%0d.overflow", i), 32'(s_ovf), 32'(tbl[i].ovf));
         chk($sformatf("tbl%0d.underflow", i), 32'(s_udf), 32'(tbl[i].udf));
         chk($sformatf("tbl%0d.data_valid", i), 32'(s_dv), 32'(tbl[i].dv));
         chk($sformatf("tbl%0d.data_out", i), 32'(s_dout), 32'(tbl[i].dout));
      end

      // Simultaneous write and read on a full FIFO
      step(0, 0, 1, 8'h00);
      step(1, 0, 0, 8'h11); step(1, 0, 0, 8'h22); step(1, 0, 0, 8'h33); step(1, 0, 0, 8'h44);
      step(1, 1, 0, 8'h66);
      chk("fullrw.level", 32'(s_level), 32'h4);
      chk("fullrw.overflow", 32'(s_ovf), 32'h0);
      step(0, 1, 0, 8'h00); chk("fullrw.rd1", 32'(s_dout), 32'h22);
      step(0, 1, 0, 8'h00); chk("fullrw.rd2", 32'(s_dout), 32'h33);
      step(0, 1, 0, 8'h00); chk("fullrw.rd3", 32'(s_dout), 32'h44);
      step(0, 1, 0, 8'h00); chk("fullrw.rd4", 32'(s_dout), 32'h66);

      // First-word-fall-through visibility and pop
      step(0, 0, 1, 8'h00);
      step(1, 0, 0, 8'hA5);
      chk("fwft.head", 32'(f_dout), 32'hA5);
      chk("fwft.valid", 32'(f_dv), 32'h1);
      step(0, 1, 0, 8'h00);
      chk("fwft.pop_empty", 32'(f_empty), 32'h1);

      // Simultaneous write and read on an empty FIFO
      step(1, 1, 0, 8'h5A);
      chk("emptyrw.level", 32'(s_level), 32'h1);
      chk("emptyrw.underflow", 32'(s_udf), 32'h1);
      chk("emptyrw.data_valid", 32'(s_dv), 32'h0);

      // Ordering across two pointer wraps
      step(0, 0, 1, 8'h00);
      for (int i = 0; i < 10; i++) begin
         step(1, 0, 0, 8'(i));
         step(0, 1, 0, 8'h00);
         chk($sformatf("wrap%0d", i), 32'(s_dout), 32'(i));
      end

      // Flush with a write pending and overflow set
      step(1, 0, 0, 8'h11); step(1, 0, 0, 8'h22); step(1, 0, 0, 8'h33); step(1, 0, 0, 8'h44);
      step(1, 0, 0, 8'h99);
      step(0, 1, 0, 8'h00);
      chk("preflush.level", 32'(s_level), 32'h3);
      chk("preflush.overflow", 32'(s_ovf), 32'h1);
      step(1, 0, 1, 8'hBB);
      chk("flush.level", 32'(s_level), 32'h0);
      chk("flush.empty", 32'(s_empty), 32'h1);
      chk("flush.overflow", 32'(s_ovf), 32'h0);
      chk("flush.data_out_held", 32'(s_dout), 32'h11);

      // Asynchronous reset in the middle of a burst
      step(1, 0, 0, 8'h01); step(1, 0, 0, 8'h02);
      write_en = 1'b0;
      #3 rst = 1'b1;
      #1;
      chk("arst.level", 32'(s_level), 32'h0);
      chk("arst.empty", 32'(s_empty), 32'h1);
      chk("arst.data_out", 32'(s_dout), 32'h0);
      chk("arst.almost_empty", 32'(f_ae), 32'h1);
      chk("arst.almost_full", 32'(f_af), 32'h0);
      model_reset();
      check_model();
      @(posedge clk);
      #1 rst = 1'b0;
      step(1, 0, 0, 8'h77);
      step(0, 1, 0, 8'h00);
      chk("arst.first_word", 32'(s_dout), 32'h77);
      chk("arst.drained", 32'(s_empty), 32'h1);

      // Random traffic against the queue model
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
              $urandom_range(0, 49) == 0, 8'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sync_fifo_flex.md
SYNC_FIFO_FLEX -- requirements
Module: sync_fifo_flex

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, number of entries; power of two, >= 4.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(FIFO_DEPTH), pointer index width.
REQ-004 SHALL have parameter AF_THRESH, default FIFO_DEPTH-2, almost-full level (1..FIFO_DEPTH).
REQ-005 SHALL have parameter AE_THRESH, default 2, almost-empty level (0..FIFO_DEPTH-1).
REQ-006 SHALL have parameter FWFT, default 0; 0 = standard registered read, 1 = first-word-fall-through.
REQ-007 SHALL have ports: clk in 1 (sole clock); rst in 1 (asynchronous, active-high reset).
REQ-008 SHALL have ports: data_in in DATA_WIDTH (write word); write_en in 1 (write request); read_en in 1 (read request/pop); flush in 1 (synchronous clear).
REQ-009 SHALL have ports: data_out out DATA_WIDTH; data_valid out 1; full out 1; empty out 1; almost_full out 1; almost_empty out 1.
REQ-010 SHALL have ports: level out ADDR_WIDTH+1 (stored word count 0..FIFO_DEPTH); overflow out 1; underflow out 1 (sticky error flags).

Function
REQ-011 Write accepted on clk edge when write_en && (!full || read accepted same cycle); word stored at write pointer, pointer +1, wrapping modulo FIFO_DEPTH.
REQ-012 Read accepted on clk edge when read_en && !empty; read pointer +1, wrapping modulo FIFO_DEPTH.
REQ-013 level: +1 on write-only, -1 on read-only, unchanged on simultaneous accepted write and read or neither.
REQ-014 full = (level == FIFO_DEPTH); empty = (level == 0); almost_full = (level >= AF_THRESH); almost_empty = (level <= AE_THRESH); all derived from registered level, no added latency.
REQ-015 Full with read_en && write_en: both accepted, level stays FIFO_DEPTH, no overflow.
REQ-016 Empty with read_en && write_en: write accepted, read rejected, underflow set.
REQ-017 FWFT=0: accepted read loads data_out with head word on that edge; data_valid high for exactly the following cycle; data_out holds otherwise.
REQ-018 FWFT=1: data_out continuously presents head word; data_valid = !empty; read_en acts as pop; word written into empty FIFO visible one cycle after write edge.
REQ-019 overflow set on write_en && full && no accepted read; underflow set on read_en && empty; both sticky until rst or flush.
REQ-020 flush: on edge, pointers and level to 0, overflow/underflow cleared, data_valid 0; write_en/read_en in flush cycle ignored; data_out unchanged (FWFT=0).
REQ-021 Rejected writes leave memory, pointers, level unchanged; rejected reads leave data_out and read pointer unchanged.
REQ-022 FIFO order strictly preserved across pointer wrap-around.

Reset
REQ-023 rst high asynchronously: pointers 0, level 0, data_out 0, data_valid 0, overflow 0, underflow 0; hence empty 1, full 0, almost_empty 1, almost_full 0.
REQ-024 Reset mid-operation discards all contents; memory array not reset; first post-reset write is the only word readable.

Structure
REQ-025 Shared package fifo_pkg SHALL hold FWFT mode constants (FIFO_MODE_STD = 0, FIFO_MODE_FWFT = 1) and default depth/width constants.
REQ-026 Storage SHALL be sub-module fifo_mem: simple dual-port array, synchronous write, asynchronous read, no reset; control logic in sync_fifo_flex.

Verification (DATA_WIDTH=8, FIFO_DEPTH=4, AF_THRESH=3, AE_THRESH=1)
REQ-027 Write 0x11,0x22,0x33,0x44 then 5th write 0x55 -> level 1,2,3,4; almost_full at level 3; full at 4; 0x55 dropped; overflow=1 sticky.
REQ-028 FWFT=0, read 4 times from full -> data_out 0x11,0x22,0x33,0x44 each with one-cycle data_valid; empty after 4th; 5th read sets underflow, data_out stays 0x44.
REQ-029 Full FIFO, write_en && read_en with 0x66 -> level stays 4, no overflow; subsequent reads return 0x22,0x33,0x44,0x66.
REQ-030 FWFT=1, write 0xA5 into empty -> next cycle data_out=0xA5, data_valid=1; read_en pops, empty=1 next cycle.
REQ-031 10 write/read pairs 0x00..0x09 spanning two pointer wraps -> output order 0x00..0x09 exactly.
REQ-032 level 3 with overflow set, pulse flush with write_en=1 -> level 0, empty 1, overflow 0, write ignored; rst mid-burst likewise yields empty with outputs at REQ-023 values.
